// File: rtl/gshare_branch_predictor.sv
// Gshare branch direction predictor: PC xor global history indexes a table of 2-bit counters.
// Define GSHARE_STATS_EN to add prediction/mispredict statistics counters.
module gshare_branch_predictor #(
  parameter int         HIST_WIDTH = 7,
  parameter logic [1:0] CNT_INIT   = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  predict_valid,
  input  logic [HIST_WIDTH-1:0] predict_pc,
  output logic                  predict_taken,
  output logic [HIST_WIDTH-1:0] predict_history,
  input  logic                  train_valid,
  input  logic                  train_taken,
  input  logic                  train_mispredicted,
  input  logic [HIST_WIDTH-1:0] train_history,
  input  logic [HIST_WIDTH-1:0] train_pc
`ifdef GSHARE_STATS_EN
  ,
  output logic [15:0]           stat_predictions,
  output logic [15:0]           stat_mispredicts
`endif
);

  localparam int PHT_DEPTH = 1 << HIST_WIDTH;

  logic [HIST_WIDTH-1:0] ghr;
  logic [HIST_WIDTH-1:0] ghr_next;
  logic [1:0]            pht [PHT_DEPTH];

  logic [HIST_WIDTH-1:0] pidx;
  logic [HIST_WIDTH-1:0] tidx;
  logic [1:0]            cnt_cur;
  logic [1:0]            cnt_next;
  logic                  repair;

  assign pidx    = predict_pc ^ ghr;
  assign tidx    = train_pc ^ train_history;
  assign repair  = train_valid && train_mispredicted;

  // The read happens before the edge, so a same-index train is not visible here.
  assign predict_taken   = pht[pidx][1];
  assign predict_history = ghr;
  assign cnt_cur         = pht[tidx];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_next = cnt_cur;
    if (train_taken) begin
      if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'b01;
    end
  end

  // A mispredict repair rebuilds history from the returned snapshot and drops any speculative shift.
  always_comb begin
    ghr_next = ghr;
    if (repair) begin
      ghr_next = {train_history[HIST_WIDTH-2:0], train_taken};
    end else if (predict_valid) begin
      ghr_next = {ghr[HIST_WIDTH-2:0], predict_taken};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
      // NOTE: the table is a flop array, not RAM, precisely so it can be cleared in one reset cycle.
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht[i] <= CNT_INIT;
      end
    end else begin
      ghr <= ghr_next;
      if (train_valid) begin
        pht[tidx] <= cnt_next;
      end
    end
  end

`ifdef GSHARE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_predictions <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (predict_valid) stat_predictions <= stat_predictions + 16'd1;
      if (repair)        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Scoreboard bench for gshare_branch_predictor: directed scenarios plus random traffic vs a table model.
module tb_gshare_branch_predictor;

  localparam int W = 7;
  localparam int D = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         predict_valid = 1'b0;
  logic [W-1:0] predict_pc = '0;
  logic         predict_taken;
  logic [W-1:0] predict_history;
  logic         train_valid = 1'b0;
  logic         train_taken = 1'b0;
  logic         train_mispredicted = 1'b0;
  logic [W-1:0] train_history = '0;
  logic [W-1:0] train_pc = '0;
`ifdef GSHARE_STATS_EN
  logic [15:0]  stat_predictions;
  logic [15:0]  stat_mispredicts;
`endif

  gshare_branch_predictor #(.HIST_WIDTH(W), .CNT_INIT(2'b01)) dut (
    .clk                (clk),
    .rst                (rst),
    .predict_valid      (predict_valid),
    .predict_pc         (predict_pc),
    .predict_taken      (predict_taken),
    .predict_history    (predict_history),
    .train_valid        (train_valid),
    .train_taken        (train_taken),
    .train_mispredicted (train_mispredicted),
    .train_history      (train_history),
`ifdef GSHARE_STATS_EN
    .train_pc           (train_pc),
    .stat_predictions   (stat_predictions),
    .stat_mispredicts   (stat_mispredicts)
`else
    .train_pc           (train_pc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    bit taken;
    int hist;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: counter values as plain integers, history as an integer.
  int   m_cnt [D];
  int   m_ghr;
  int   m_npred;
  int   m_nmis;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < D; i++) m_cnt[i] = 1;
    m_ghr   = 0;
    m_npred = 0;
    m_nmis  = 0;
  endfunction

  // One cycle: drive inputs, queue the expected prediction, then advance the model past the edge.
  task automatic step(input bit pv, input int ppc, input bit tv, input bit tt,
                      input bit tm, input int th, input int tpc);
    bit pred;
    int next_ghr;
    predict_valid      = pv;
    predict_pc         = W'(ppc);
    train_valid        = tv;
    train_taken        = tt;
    train_mispredicted = tm;
    train_history      = W'(th);
    train_pc           = W'(tpc);
    pred = (m_cnt[(ppc ^ m_ghr) % D] >= 2);
    if (pv) exp_q.push_back('{pc: ppc, taken: pred, hist: m_ghr});
    @(posedge clk);
    next_ghr = m_ghr;
    if (tv && tm)  next_ghr = ((th * 2) + int'(tt)) % D;
    else if (pv)   next_ghr = ((m_ghr * 2) + int'(pred)) % D;
    if (tv) begin
      int k;
      k = (tpc ^ th) % D;
      if (tt) m_cnt[k] = (m_cnt[k] < 3) ? m_cnt[k] + 1 : 3;
      else    m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
    end
    m_ghr = next_ghr;
    if (pv) m_npred = (m_npred + 1) % 65536;
    if (tv && tm) m_nmis = (m_nmis + 1) % 65536;
    #1;
  endtask

  task automatic do_reset();
    predict_valid = 1'b0;
    train_valid   = 1'b0;
    rst           = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic sweep_all_pcs();
    for (int pc = 0; pc < D; pc++) step(1'b1, pc, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_stats();
`ifdef GSHARE_STATS_EN
    check("stat_predictions", int'(stat_predictions), m_npred);
    check("stat_mispredicts", int'(stat_mispredicts), m_nmis);
`endif
  endtask

  // Monitor: every cycle with a prediction request pops one expectation and compares.
  always @(negedge clk) begin
    if (!rst && predict_valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard_underflow: got prediction with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("predict_taken pc=%0d", e.pc), int'(predict_taken), int'(e.taken));
        check($sformatf("predict_history pc=%0d", e.pc), int'(predict_history), e.hist);
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("reset_history", int'(predict_history), 0);
    sweep_all_pcs();

    // Speculative shift of a not-taken prediction, then a repair to history 1.
    step(1'b1, 10, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 0, 1'b1, 1'b1, 1'b1, 0, 10);
    check("ghr_after_repair", int'(predict_history), 1);
    step(1'b1, 10, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1, 10);
    check("ghr_no_repair", int'(predict_history), 2);

    // Saturation up, then down.
    repeat (3) step(1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 20);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1, 0, 0);
    step(1'b1, 20, 1'b0, 1'b0, 1'b0, 0, 0);
    check("sat_high_ghr", int'(predict_history), 1);
    repeat (4) step(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 20);
    step(1'b0, 0, 1'b1, 1'b1, 1'b1, 0, 0);
    step(1'b1, 20, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 20);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1, 0, 0);
    step(1'b1, 20, 1'b0, 1'b0, 1'b0, 0, 0);

    // Same-edge predict and mispredict repair: repair wins.
    step(1'b1, 3, 1'b1, 1'b0, 1'b1, 'h55, 9);
    check("simul_repair_ghr", int'(predict_history), 'h2A);
    // Same-edge predict and correct train: speculative shift applies.
    step(1'b1, 0, 1'b1, 1'b1, 1'b0, 'h12, 9);

    // Same-cycle read/write of one index: prediction sees the old counter.
    for (int r = 0; r < 6; r++) begin
      int h;
      h = m_ghr;
      step(1'b1, 40, 1'b1, 1'b1, 1'b0, h, 40);
    end

    // Random traffic, half of it focused on a few PCs to exercise saturation.
    for (int n = 0; n < 3000; n++) begin
      int ppc, tpc, th;
      ppc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, D - 1);
      tpc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, D - 1);
      th  = ($urandom_range(0, 3) == 0) ? m_ghr : $urandom_range(0, D - 1);
      step(1'($urandom_range(0, 1)), ppc, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), th, tpc);
    end
    check_stats();

    // Mid-operation reset returns every counter to weakly not-taken.
    do_reset();
    check("midreset_history", int'(predict_history), 0);
    check_stats();
    sweep_all_pcs();
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
